// File: rtl/lsu_sequencer.sv
// rtl/lsu_sequencer.sv - multi-cycle load/store sequencer between execute and the data memory bus.
// Optional misaligned-access trap is enabled by defining LSU_MISALIGN_TRAP_EN.
module lsu_sequencer #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic        done,
  output logic        err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_R, RESP} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       size_q;
  logic [1:0]       off_q;
  logic             unsigned_q;
  logic             mem_we_q;
  logic [31:0]      mem_addr_q;
  logic [3:0]       mem_be_q;
  logic [31:0]      mem_wdata_q;
  logic             wb_valid_q;
  logic [31:0]      wb_data_q;
  logic             done_q;
  logic             err_q;

  logic [3:0]       be_d;
  logic [31:0]      wdata_d;
  logic             misalign_d;
  logic [7:0]       byte_v;
  logic [15:0]      half_v;
  logic [31:0]      ld_data_d;

  // Lane selection and store-data replication from the incoming request.
  always_comb begin
    be_d    = 4'b1111;
    wdata_d = req_wdata;
    case (req_size)
      2'd0: begin
        be_d    = 4'b0001 << req_addr[1:0];
        wdata_d = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        be_d    = 4'b0011 << {req_addr[1], 1'b0};
        wdata_d = {2{req_wdata[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = req_wdata;
      end
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign_d = ((req_size == 2'd1) && req_addr[0]) ||
                      (req_size[1] && (req_addr[1:0] != 2'b00));
`else
  assign misalign_d = 1'b0;
`endif

  // Load extraction uses the offset captured at accept time.
  always_comb begin
    byte_v    = mem_rdata[{off_q, 3'b000} +: 8];
    half_v    = mem_rdata[{off_q[1], 4'b0000} +: 16];
    ld_data_d = mem_rdata;
    case (size_q)
      2'd0:    ld_data_d = {{24{~unsigned_q & byte_v[7]}}, byte_v};
      2'd1:    ld_data_d = {{16{~unsigned_q & half_v[15]}}, half_v};
      default: ld_data_d = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      size_q      <= 2'd0;
      off_q       <= 2'd0;
      unsigned_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_be_q    <= 4'd0;
      mem_wdata_q <= 32'd0;
      wb_valid_q  <= 1'b0;
      wb_data_q   <= 32'd0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      wb_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            mem_we_q    <= req_store;
            mem_addr_q  <= {req_addr[31:2], 2'b00};
            mem_be_q    <= be_d;
            mem_wdata_q <= wdata_d;
            size_q      <= req_size;
            off_q       <= req_addr[1:0];
            unsigned_q  <= req_unsigned;
            if (misalign_d) begin
              err_q   <= 1'b1;
              state_q <= RESP;
            end else begin
              state_q <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (mem_gnt) begin
            if (mem_we_q) begin
              done_q  <= 1'b1;
              state_q <= RESP;
            end else begin
              cnt_q   <= '0;
              state_q <= WAIT_R;
            end
          end
        end
        WAIT_R: begin
          if (mem_rvalid) begin
            wb_data_q  <= ld_data_d;
            wb_valid_q <= 1'b1;
            state_q    <= RESP;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            err_q   <= 1'b1;
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        // Pulse cycle: holds off req_ready so a new request follows one cycle later.
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign mem_req   = (state_q == ISSUE);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
  assign wb_valid  = wb_valid_q;
  assign wb_data   = wb_data_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: doc/lsu_sequencer.md
Name: lsu_sequencer

Overview:
- Multi-cycle load/store sequencer between the execute stage (ALU, address generation) and the data memory port.
- Accepts one memory operation at a time over a valid/ready handshake and drives a req/gnt/rvalid memory bus.
- Returns sign- or zero-extended load data for writeback; produces byte enables and replicated write data for stores.
- Flags bus timeout and, optionally, misaligned access.

Parameters:
- TIMEOUT, 15, max cycles in WAIT_R without mem_rvalid before error (1..255)
- CNT_W, 8, width of timeout counter

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  execute stage presents an operation
- req_ready  out  1  sequencer can accept
- req_store  in  1  1=store, 0=load
- req_size  in  2  0=byte, 1=half, 2/3=word
- req_unsigned  in  1  zero-extend load (LBU/LHU)
- req_addr  in  32  byte address
- req_wdata  in  32  store data (rs2)
- mem_req  out  1  bus request
- mem_gnt  in  1  bus grant
- mem_we  out  1  write enable
- mem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- mem_be  out  4  byte enables
- mem_wdata  out  32  replicated write data
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read word
- wb_valid  out  1  one-cycle pulse, load result valid
- wb_data  out  32  extended load result, held until next load result
- done  out  1  one-cycle pulse, store granted
- err  out  1  one-cycle pulse, timeout or misalign
- busy  out  1  state != IDLE

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clk, reset).
- Reset: state=IDLE; all outputs 0; req_ready=1 in the first cycle after reset. Reset mid-operation abandons the transaction with no done/err/wb_valid.
- States: IDLE, ISSUE, WAIT_R, RESP. All outputs are registered or decoded from registered state.
- IDLE:
  - req_ready=1.
  - On req_valid: capture store, size, unsigned, addr and wdata; go to ISSUE.
  - req_ready=0 in every other state.
- ISSUE:
  - mem_req=1; mem_addr, mem_we, mem_be and mem_wdata stable until mem_gnt.
  - On mem_gnt: a store pulses done next cycle and returns to IDLE; a load clears the counter and goes to WAIT_R.
- WAIT_R:
  - mem_req=0; counter increments each cycle.
  - On mem_rvalid: register the extracted data into wb_data and go to RESP.
  - If the counter reaches TIMEOUT with no rvalid: err pulse, return to IDLE.
  - rvalid arriving on the same cycle as gnt is ignored. rvalid in IDLE or ISSUE is ignored.
- RESP: wb_valid=1 for one cycle, then IDLE.
- Latency with immediate grant (accept at cycle 0): mem_req at cycle 1; store done at cycle 2; load rvalid earliest at cycle 2, wb_valid at cycle 3.
- Byte enables: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<{addr[1],1'b0}; word = 4'b1111.
- Write data: byte = {4{wdata[7:0]}}; half = {2{wdata[15:0]}}; word = wdata.
- Load extract: offset = addr[1:0]*8.
  - Byte: rdata[offset+:8], sign- or zero-extended.
  - Half: rdata[{addr[1],4'b0}+:16], extended.
  - Word: rdata unchanged.
- mem_gnt while mem_req=0 is ignored.
- Back-to-back: req_ready returns the cycle after done, err or wb_valid.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: a half access with addr[0]=1 or a word access with addr[1:0]!=0 is accepted but not issued. The FSM goes IDLE->RESP-equivalent error path: err pulses in cycle 1, mem_req stays 0, return to IDLE.
- Undefined: the low offending address bits are ignored. Half uses addr[1] only; word is treated as aligned. No error is raised.

Test Plan:
- Load word, addr=0x100, gnt immediate, rvalid at cycle 2, rdata=0xDEADBEEF -> mem_addr=0x100, mem_be=4'b1111, mem_we=0; wb_valid at cycle 3 with wb_data=0xDEADBEEF.
- LB addr=0x103, rdata=0x80112233 -> wb_data=0xFFFFFF80. Same access as LBU -> wb_data=0x00000080. LH addr=0x102 -> wb_data=0xFFFF8011.
- SB addr=0x201, wdata=0x000000A5, gnt delayed 3 cycles -> mem_req held 3 cycles with stable outputs, mem_be=4'b0010, mem_wdata=0xA5A5A5A5; done single pulse; req_ready low throughout.
- Load with no rvalid, TIMEOUT=15 -> err pulses after 15 WAIT_R cycles, wb_valid never asserts, req_ready=1 next cycle.
- Reset asserted while in WAIT_R -> next cycle state=IDLE, all outputs 0; a late rvalid is ignored with no wb_valid.
- SW addr=0x102: with LSU_MISALIGN_TRAP_EN -> err at cycle 1 and no mem_req; without it -> mem_addr=0x100, mem_be=4'b1111, done pulse.
